data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 101 ++++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-cycle data memory for a simple core.
// Reads are combinational (zero latency) and writes commit on the rising edge.
// A read of the word being written returns the old contents.
//
// Optional feature: define DATA_MEM_MMIO_EN to map the top four word
// addresses onto registers instead of RAM:
//   top-0 GPIO (RW, low 8 bits)   top-1 cycle counter (RO)
//   top-2 store counter (RO)      top-3 ID constant (RO)
// Without the macro every address is plain RAM and gpio_o is tied to zero.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] val_write_i,
    output logic [DATA_WIDTH-1:0] val_read_o,
    output logic [7:0]            gpio_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Word storage; contents are deliberately left untouched by reset.
    logic [DATA_WIDTH-1:0] mem_array [DEPTH];
    logic                  ram_we;

`ifdef DATA_MEM_MMIO_EN
    localparam logic [31:0] MMIO_ID = 32'h5256_3332;

    logic        is_mmio;
    logic [7:0]  gpio_q,      gpio_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;

    // The four register words share an all-ones upper address field.
    assign is_mmio = &addr_i[ADDR_WIDTH-1:2];
    // Only RAM-region stores reach the array; register writes never do.
    assign ram_we  = we_i & ~rst & ~is_mmio;

    // Next-state for GPIO and both counters (reset is applied in the register).
    always_comb begin
        gpio_d      = gpio_q;
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        store_cnt_d = store_cnt_q;
        if (we_i && is_mmio && (addr_i[1:0] == 2'b11)) begin
            gpio_d = val_write_i[7:0];
        end
        if (ram_we && (store_cnt_q != 32'hFFFF_FFFF)) begin
            store_cnt_d = store_cnt_q + 32'd1;
        end
    end

    // Register state; a reset cycle clears the registers and is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q      <= 8'h00;
            cycle_cnt_q <= 32'd0;
            store_cnt_q <= 32'd0;
        end else begin
            gpio_q      <= gpio_d;
            cycle_cnt_q <= cycle_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // Read mux: registers show their current (pre-update) values.
    always_comb begin
        val_read_o = mem_array[addr_i];
        if (is_mmio) begin
            case (addr_i[1:0])
                2'b11:   val_read_o = DATA_WIDTH'(gpio_q);
                2'b10:   val_read_o = DATA_WIDTH'(cycle_cnt_q);
                2'b01:   val_read_o = DATA_WIDTH'(store_cnt_q);
                default: val_read_o = DATA_WIDTH'(MMIO_ID);
            endcase
        end
    end

    assign gpio_o = gpio_q;
`else
    // Every address is RAM; writes are blocked while in reset.
    assign ram_we = we_i & ~rst;

    // Plain combinational read of the addressed word.
    always_comb begin
        val_read_o = mem_array[addr_i];
    end

    assign gpio_o = 8'h00;
`endif

    // Array write port; the read above sees the old word until this edge.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_array[addr_i] <= val_write_i;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios followed by random
// traffic, all compared with a behavioural model of the memory map.
module tb_data_mem_responder;

`ifdef DATA_MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [9:0]  addr_i;
    logic [31:0] val_write_i;
    logic [31:0] val_read_o;
    logic [7:0]  gpio_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit [31:0] ram_m [int];
    bit [7:0]  gpio_m = 8'h00;
    bit [31:0] cyc_m  = 32'd0;
    bit [31:0] st_m   = 32'd0;

    data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .val_write_i (val_write_i),
        .val_read_o  (val_read_o),
        .gpio_o      (gpio_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Expected read value for an address; known=0 when RAM was never written.
    function automatic bit [31:0] model_read(input bit [9:0] a, output bit known);
        known = 1'b1;
        if (MMIO && a >= 10'h3FC) begin
            case (a)
                10'h3FF: return {24'd0, gpio_m};
                10'h3FE: return cyc_m;
                10'h3FD: return st_m;
                default: return 32'h5256_3332;
            endcase
        end
        if (ram_m.exists(int'(a))) return ram_m[int'(a)];
        known = 1'b0;
        return 32'd0;
    endfunction

    // Drive one cycle's inputs mid-period and compare against the model.
    task automatic apply(input bit r, input bit w, input bit [9:0] a, input bit [31:0] d);
        bit [31:0] exp;
        bit        known;
        @(negedge clk);
        rst = r; we_i = w; addr_i = a; val_write_i = d;
        #1;
        exp = model_read(a, known);
        if (known) check_val("rd_model", val_read_o, exp);
        check_val("gpio_model", {24'd0, gpio_o}, {24'd0, gpio_m});
        $display("cyc rst=%0b we=%0b addr=%03h wdata=%08h rdata=%08h gpio=%02h",
                 r, w, a, d, val_read_o, gpio_o);
    endtask

    // Advance through the rising edge and update the model from the held inputs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            gpio_m = 8'h00;
            cyc_m  = 32'd0;
            st_m   = 32'd0;
        end else begin
            if (MMIO) cyc_m = cyc_m + 32'd1;
            if (we_i) begin
                if (MMIO && addr_i >= 10'h3FC) begin
                    if (addr_i == 10'h3FF) gpio_m = val_write_i[7:0];
                end else begin
                    ram_m[int'(addr_i)] = val_write_i;
                    if (MMIO && st_m != 32'hFFFF_FFFF) st_m = st_m + 32'd1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; addr_i = 10'd0; val_write_i = 32'd0;

        // Reset state
        apply(1, 0, 10'h000, 32'd0);
        tick(); tick(); tick();
        apply(1, 0, 10'h3FE, 32'd0);
        check_val("rst_gpio", {24'd0, gpio_o}, 32'h0000_0000);
        if (MMIO) check_val("rst_cycle_cnt", val_read_o, 32'd0);
        tick();

        // Write then read; same-cycle read returns old data; last write wins
        apply(0, 1, 10'h010, 32'h1111_1111); tick();
        apply(0, 1, 10'h010, 32'hDEAD_BEEF);
        check_val("same_cycle_old", val_read_o, 32'h1111_1111);
        tick();
        apply(0, 0, 10'h010, 32'd0);
        check_val("read_next_cycle", val_read_o, 32'hDEAD_BEEF);
        tick();
        apply(0, 1, 10'h011, 32'hAAAA_0001); tick();
        apply(0, 1, 10'h011, 32'h5555_0002); tick();
        apply(0, 0, 10'h011, 32'd0);
        check_val("back_to_back", val_read_o, 32'h5555_0002);
        tick();

        // Write during reset is blocked
        apply(0, 1, 10'h020, 32'hCAFE_0001); tick();
        apply(1, 1, 10'h020, 32'h1234_5678);
        check_val("rd_during_rst", val_read_o, 32'hCAFE_0001);
        tick();
        apply(0, 0, 10'h020, 32'd0);
        check_val("rst_blocks_write", val_read_o, 32'hCAFE_0001);
        tick();
        if (MMIO) begin
            apply(0, 0, 10'h3FD, 32'd0);
            check_val("store_cnt_after_rst", val_read_o, 32'd0);
            tick();
        end

        if (!MMIO) begin
            // Top address is ordinary RAM and GPIO stays zero
            apply(0, 1, 10'h3FF, 32'h0BAD_F00D); tick();
            apply(0, 0, 10'h3FF, 32'd0);
            check_val("top_is_ram", val_read_o, 32'h0BAD_F00D);
            check_val("gpio_tied_zero", {24'd0, gpio_o}, 32'd0);
            tick();
        end else begin
            // GPIO write, readback, and reset clear
            apply(0, 1, 10'h3FF, 32'h0000_01A5); tick();
            apply(0, 0, 10'h3FF, 32'd0);
            check_val("gpio_out", {24'd0, gpio_o}, 32'h0000_00A5);
            check_val("gpio_read", val_read_o, 32'h0000_00A5);
            tick();
            apply(1, 0, 10'h3FF, 32'd0); tick();
            apply(0, 0, 10'h3FF, 32'd0);
            check_val("gpio_rst", {24'd0, gpio_o}, 32'd0);
            tick();

            // Cycle counter after 10 idle cycles, store counter, ID write ignored
            apply(1, 0, 10'h3FE, 32'd0); tick();
            for (int i = 0; i < 10; i++) begin
                apply(0, 0, 10'h3FE, 32'd0); tick();
            end
            apply(0, 0, 10'h3FE, 32'd0);
            check_val("cycle_cnt_10", val_read_o, 32'd10);
            tick();
            for (int i = 0; i < 3; i++) begin
                apply(0, 1, 10'h030 + 10'(i), 32'h100 + 32'(i)); tick();
            end
            apply(0, 1, 10'h3FC, 32'hFFFF_FFFF); tick();
            apply(0, 0, 10'h3FD, 32'd0);
            check_val("store_cnt_3", val_read_o, 32'd3);
            tick();
            apply(0, 0, 10'h3FC, 32'd0);
            check_val("id_const", val_read_o, 32'h5256_3332);
            tick();

`ifdef DATA_MEM_MMIO_EN
            // Cycle counter wrap
            #1;
            dut.cycle_cnt_q = 32'hFFFF_FFFE;
            cyc_m = 32'hFFFF_FFFE;
`endif
            apply(0, 0, 10'h3FE, 32'd0);
            check_val("cyc_wrap_0", val_read_o, 32'hFFFF_FFFE); tick();
            apply(0, 0, 10'h3FE, 32'd0);
            check_val("cyc_wrap_1", val_read_o, 32'hFFFF_FFFF); tick();
            apply(0, 0, 10'h3FE, 32'd0);
            check_val("cyc_wrap_2", val_read_o, 32'h0000_0000); tick();
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit [9:0]  a;
            bit        r;
            bit        w;
            case ($urandom_range(0, 7))
                0: a = 10'h010;
                1: a = 10'h011;
                2: a = 10'h020;
                3: a = 10'h3FC;
                4: a = 10'h3FD;
                5: a = 10'h3FE;
                6: a = 10'h3FF;
                default: a = 10'($urandom_range(0, 1023));
            endcase
            r = ($urandom_range(0, 19) == 0);
            w = ($urandom_range(0, 1) == 1);
            apply(r, w, a, $urandom());
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
